// File: rtl/arb_pkg.sv
// Shared definitions for the ten-way decimal request arbiter and its
// one-hot to BCD helper.
//   N_REQ       : number of requesters (indices 0..9)
//   BCD_W       : width of a BCD requester index
//   arb_state_t : arbiter FSM state
//   wrap_inc    : modulo-10 increment of a BCD index
package arb_pkg;

  localparam int N_REQ = 10;
  localparam int BCD_W = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  // 9 (and any out-of-range code) wraps back to 0.
  function automatic logic [BCD_W-1:0] wrap_inc(input logic [BCD_W-1:0] v);
    return (v >= 4'd9) ? 4'd0 : v + 4'd1;
  endfunction

endpackage

// File: rtl/onehot10_to_bcd.sv
// Combinational 10-bit one-hot to 4-bit BCD index encoder.
//   onehot : in  10 -- one-hot vector, bit i selects index i
//   bcd    : out 4  -- BCD index 0000..1001; 0000 for zero or multi-hot input
module onehot10_to_bcd
  import arb_pkg::*;
(
  input  logic [N_REQ-1:0] onehot,
  output logic [BCD_W-1:0] bcd
);

  always_comb begin
    bcd = '0;
    case (onehot)
      10'b00_0000_0001: bcd = 4'd0;
      10'b00_0000_0010: bcd = 4'd1;
      10'b00_0000_0100: bcd = 4'd2;
      10'b00_0000_1000: bcd = 4'd3;
      10'b00_0001_0000: bcd = 4'd4;
      10'b00_0010_0000: bcd = 4'd5;
      10'b00_0100_0000: bcd = 4'd6;
      10'b00_1000_0000: bcd = 4'd7;
      10'b01_0000_0000: bcd = 4'd8;
      10'b10_0000_0000: bcd = 4'd9;
      default:          bcd = '0;
    endcase
  end

endmodule

// File: rtl/decimal_req_arbiter.sv
// Round-robin arbiter sharing one downstream resource among ten requesters.
// A grant is held while its owner keeps requesting, up to MAX_HOLD cycles,
// and every ownership ends with one idle bubble cycle.
//   clk         : in  1  -- rising-edge clock
//   rst_n       : in  1  -- asynchronous active-low reset
//   req         : in  10 -- request lines, bit i = requester i
//   grant       : out 10 -- registered one-hot grant, zero when idle
//   grant_bcd   : out 4  -- registered BCD index of the owner, 0000 when idle
//   grant_valid : out 1  -- registered, high while a grant is active
//   forced_rel  : out 1  -- registered one-cycle pulse on hold-limit timeout
module decimal_req_arbiter
  import arb_pkg::*;
#(
  parameter int MAX_HOLD = 15
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] grant,
  output logic [BCD_W-1:0] grant_bcd,
  output logic             grant_valid,
  output logic             forced_rel
);

  localparam logic [BCD_W-1:0] HOLD_LIMIT = BCD_W'(MAX_HOLD);

  arb_state_t       state, state_n;
  logic [BCD_W-1:0] ptr, ptr_n;
  logic [BCD_W-1:0] owner, owner_n;
  logic [BCD_W-1:0] hold_cnt, hold_n;
  logic             forced_n;
  logic [N_REQ-1:0] grant_n;
  logic [BCD_W-1:0] bcd_n;

  // First set request scanning start, start+1, ..., 9, 0, ..., start-1.
  function automatic logic [BCD_W-1:0] rr_pick(input logic [N_REQ-1:0] r,
                                               input logic [BCD_W-1:0] start);
    logic [BCD_W-1:0] idx;
    logic [BCD_W-1:0] sel;
    logic             found;
    idx   = start;
    sel   = start;
    found = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (!found && r[idx]) begin
        found = 1'b1;
        sel   = idx;
      end
      idx = wrap_inc(idx);
    end
    return sel;
  endfunction

  always_comb begin
    state_n  = state;
    ptr_n    = ptr;
    owner_n  = owner;
    hold_n   = hold_cnt;
    forced_n = 1'b0;
    case (state)
      IDLE: begin
        if (|req) begin
          owner_n = rr_pick(req, ptr);
          hold_n  = 4'd1;
          state_n = GRANT;
        end
      end
      GRANT: begin
        // A voluntary release wins over a timeout landing on the same edge.
        if (!req[owner]) begin
          state_n = IDLE;
          ptr_n   = wrap_inc(owner);
          hold_n  = '0;
        end else if (hold_cnt == HOLD_LIMIT) begin
          state_n  = IDLE;
          ptr_n    = wrap_inc(owner);
          hold_n   = '0;
          forced_n = 1'b1;
        end else begin
          hold_n = hold_cnt + 4'd1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Outputs are registered from the next-state view so the grant appears
  // on the same edge that moves the FSM into GRANT.
  assign grant_n = (state_n == GRANT) ? (N_REQ'(1) << owner_n) : '0;

  onehot10_to_bcd u_bcd (
    .onehot (grant_n),
    .bcd    (bcd_n)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      ptr         <= '0;
      owner       <= '0;
      hold_cnt    <= '0;
      grant       <= '0;
      grant_bcd   <= '0;
      grant_valid <= 1'b0;
      forced_rel  <= 1'b0;
    end else begin
      state       <= state_n;
      ptr         <= ptr_n;
      owner       <= owner_n;
      hold_cnt    <= hold_n;
      grant       <= grant_n;
      grant_bcd   <= bcd_n;
      grant_valid <= (state_n == GRANT);
      forced_rel  <= forced_n;
    end
  end

endmodule

// File: tb/tb_decimal_req_arbiter.sv
// Scoreboard bench for decimal_req_arbiter: stimulus pushes the reference
// model's expected outputs for each edge, a monitor pops and compares them.
module tb_decimal_req_arbiter;

  localparam int MAX_HOLD = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [9:0] req = '0;
  logic [9:0] grant;
  logic [3:0] grant_bcd;
  logic       grant_valid;
  logic       forced_rel;

  always #5 clk = ~clk;

  decimal_req_arbiter #(.MAX_HOLD(MAX_HOLD)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (req),
    .grant       (grant),
    .grant_bcd   (grant_bcd),
    .grant_valid (grant_valid),
    .forced_rel  (forced_rel)
  );

  typedef struct packed {
    logic [9:0] g;
    logic [3:0] b;
    logic       v;
    logic       f;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  bit   armed = 1'b0;
  bit   done = 1'b0;

  // Reference model: who owns the resource, for how long, and where the
  // round-robin scan starts next.
  int m_busy, m_owner, m_held, m_ptr, m_forced;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, want, $time);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_owner = 0; m_held = 0; m_ptr = 0; m_forced = 0;
  endtask

  task automatic model_step(input logic [9:0] r);
    m_forced = 0;
    if (m_busy == 0) begin
      if (r != 0) begin
        for (int i = 0; i < 10; i++) begin
          int c;
          c = (m_ptr + i) % 10;
          if (r[c]) begin
            m_owner = c;
            break;
          end
        end
        m_busy = 1;
        m_held = 1;
      end
    end else if (!r[m_owner]) begin
      m_busy = 0;
      m_ptr  = (m_owner + 1) % 10;
    end else if (m_held == MAX_HOLD) begin
      m_busy   = 0;
      m_ptr    = (m_owner + 1) % 10;
      m_forced = 1;
    end else begin
      m_held++;
    end
  endtask

  function automatic exp_t model_out();
    exp_t e;
    e.g = (m_busy != 0) ? (10'd1 << m_owner) : 10'd0;
    e.b = (m_busy != 0) ? 4'(m_owner) : 4'd0;
    e.v = (m_busy != 0);
    e.f = (m_forced != 0);
    return e;
  endfunction

  // Drive one cycle's inputs at the falling edge and queue what the next
  // rising edge must produce.
  task automatic step(input logic [9:0] r, input logic rst_v);
    @(negedge clk);
    req   = r;
    rst_n = rst_v;
    if (!rst_v) model_reset();
    else        model_step(r);
    exp_q.push_back(model_out());
    armed = 1'b1;
  endtask

  task automatic expect_now(input string name, input logic [9:0] g, input logic [3:0] b);
    @(posedge clk);
    #2;
    chk({name, "_grant"}, 32'(grant), 32'(g));
    chk({name, "_bcd"}, 32'(grant_bcd), 32'(b));
  endtask

  // Monitor
  initial begin
    exp_t e;
    wait (armed);
    forever begin
      @(posedge clk);
      #1;
      if (!done) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL scoreboard_empty: no expectation queued at %0t", $time);
        end else begin
          e = exp_q.pop_front();
          chk("grant", 32'(grant), 32'(e.g));
          chk("grant_bcd", 32'(grant_bcd), 32'(e.b));
          chk("grant_valid", 32'(grant_valid), 32'(e.v));
          chk("forced_rel", 32'(forced_rel), 32'(e.f));
          chk("grant_onehot", 32'($countones(grant) <= 1), 32'd1);
          if (grant_valid) chk("bcd_matches_grant", 32'(grant[grant_bcd]), 32'd1);
        end
      end
    end
  end

  // Stimulus
  initial begin
    logic [9:0] r;
    logic [9:0] prev;
    model_reset();

    // Reset asserted with every request high, before any clock edge.
    req = 10'h3FF;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_bcd", 32'(grant_bcd), 32'd0);
    chk("rst_valid", 32'(grant_valid), 32'd0);
    chk("rst_forced", 32'(forced_rel), 32'd0);
    for (int k = 0; k < 3; k++) step(10'h3FF, 1'b0);

    // Rotation: every owner drops its request after two grant cycles.
    for (int k = 0; k < 31; k++) begin
      r = 10'h3FF;
      if (m_busy != 0 && m_held == 2) r[m_owner] = 1'b0;
      step(r, 1'b1);
      if (k == 0) expect_now("first", 10'h001, 4'd0);
    end
    for (int k = 0; k < 60 && !(m_busy == 0 && m_ptr == 9); k++) begin
      r = 10'h3FF;
      if (m_busy != 0 && m_held == 2) r[m_owner] = 1'b0;
      step(r, 1'b1);
    end

    // Pointer wrap: owner 9 first, then 0.
    for (int k = 0; k < 12; k++) begin
      step(10'h201, 1'b1);
      if (k == 0) expect_now("wrap", 10'h200, 4'd9);
    end
    step(10'h000, 1'b1);
    step(10'h000, 1'b1);

    // Timeout between requesters 2 and 5.
    for (int k = 0; k < 12; k++) begin
      step(10'h024, 1'b1);
      if (k == 0) expect_now("timeout", 10'h004, 4'd2);
    end

    // Single requester repeatedly timing out.
    for (int k = 0; k < 12; k++) step(10'h080, 1'b1);
    step(10'h000, 1'b1);
    step(10'h000, 1'b1);

    // Asynchronous reset while requester 6 holds the grant.
    step(10'h040, 1'b1);
    step(10'h040, 1'b1);
    @(negedge clk);
    chk("pre_reset_grant", 32'(grant), 32'h040);
    #2 rst_n = 1'b0;
    #1;
    chk("async_grant", 32'(grant), 32'd0);
    chk("async_bcd", 32'(grant_bcd), 32'd0);
    chk("async_valid", 32'(grant_valid), 32'd0);
    chk("async_forced", 32'(forced_rel), 32'd0);
    model_reset();
    exp_q.push_back(model_out());
    step(10'h3FF, 1'b0);
    step(10'h3FF, 1'b1);
    expect_now("restart", 10'h001, 4'd0);

    // Randomized traffic.
    prev = 10'h3FF;
    for (int k = 0; k < 400; k++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3: r = 10'($urandom);
        4, 5:       r = 10'd1 << $urandom_range(0, 9);
        6:          r = '0;
        default: begin
          r = prev;
          if (m_busy != 0 && $urandom_range(0, 9) < 3) r[m_owner] = 1'b0;
        end
      endcase
      prev = r;
      step(r, (k == 200 || k == 201) ? 1'b0 : 1'b1);
    end

    step(10'h000, 1'b1);
    step(10'h000, 1'b1);
    @(posedge clk);
    #2;
    done = 1'b1;
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, %0d errors so far", errors);
    $fatal(1, "watchdog");
  end

endmodule
